// File: rtl/pmem_arbiter_if.sv
// Line-granular memory port: one requester (master) issues read/write of a whole
// cache line and waits for resp; the responder (slave) returns rdata with resp.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output read, write, address, wdata, input rdata, resp);
    modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one pmem line port between I-cache and D-cache misses,
// one latched transaction at a time, with a sticky bus-stall watchdog.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int TMO_W  = 10
) (
    input  logic           clk,
    input  logic           rst,
    pmem_arbiter_if.slave  i_mem,
    pmem_arbiter_if.slave  d_mem,
    pmem_arbiter_if.master pmem,
    output logic           timeout_err
);
    typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    owner_t           grant;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_next;
    logic             req_i;
    logic             req_d;
    logic             sel_read;
    logic             sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [LINE_W-1:0] sel_wdata;
    logic             serve_resp;

    assign req_i    = i_mem.read | i_mem.write;
    assign req_d    = d_mem.read | d_mem.write;
    assign cnt_next = cnt + TMO_W'(1);

    always_comb begin
        grant = OWN_I;
        if (req_d && (!req_i || last_grant == OWN_I))
            grant = OWN_D;
        sel_read    = i_mem.read;
        sel_write   = i_mem.write;
        sel_address = i_mem.address;
        sel_wdata   = i_mem.wdata;
        if (grant == OWN_D) begin
            sel_read    = d_mem.read;
            sel_write   = d_mem.write;
            sel_address = d_mem.address;
            sel_wdata   = d_mem.wdata;
        end
    end

    // Gated by rst so a reset cycle that coincides with pmem_resp never completes a request.
    assign serve_resp  = (state == SERVE) && pmem.resp && rst;
    assign i_mem.resp  = serve_resp && (owner == OWN_I);
    assign d_mem.resp  = serve_resp && (owner == OWN_D);
    assign i_mem.rdata = pmem.rdata;
    assign d_mem.rdata = pmem.rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= OWN_I;
            last_grant   <= OWN_D;
            pmem.read    <= 1'b0;
            pmem.write   <= 1'b0;
            pmem.address <= '0;
            pmem.wdata   <= '0;
            cnt          <= '0;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        owner        <= grant;
                        last_grant   <= grant;
                        pmem.address <= sel_address;
                        pmem.wdata   <= sel_wdata;
                        pmem.write   <= sel_write;
                        pmem.read    <= sel_read & ~sel_write;
                        cnt          <= '0;
                        state        <= SERVE;
                    end
                end
                SERVE: begin
                    if (pmem.resp) begin
                        pmem.read  <= 1'b0;
                        pmem.write <= 1'b0;
                        cnt        <= '0;
                        state      <= RELEASE;
                    end else if (cnt != '1) begin
                        // Flag fires on the edge where the count first reaches all-ones.
                        cnt <= cnt_next;
                        if (&cnt_next)
                            timeout_err <= 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed-vector bench for pmem_arbiter: grant order, latching, latency,
// watchdog and mid-transaction reset, each against hand-computed values.
module tb_pmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int TMO_W  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timeout_err;

    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) p_bus ();

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem       (i_bus),
        .d_mem       (d_bus),
        .pmem        (p_bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;
    logic [LINE_W-1:0] pattern_a5;
    logic [LINE_W-1:0] rline;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Completes the current transaction; expects exactly one of the two resp lines.
    task automatic respond(input string tag, input logic exp_i, input logic [LINE_W-1:0] data);
        p_bus.resp  = 1'b1;
        p_bus.rdata = data;
        #1;
        check({tag, "_i_resp"}, LINE_W'(i_bus.resp), LINE_W'(exp_i));
        check({tag, "_d_resp"}, LINE_W'(d_bus.resp), LINE_W'(!exp_i));
        check({tag, "_rdata"}, exp_i ? i_bus.rdata : d_bus.rdata, data);
    endtask

    initial begin
        {i_bus.read, i_bus.write, i_bus.address, i_bus.wdata} = '0;
        {d_bus.read, d_bus.write, d_bus.address, d_bus.wdata} = '0;
        p_bus.resp  = 1'b0;
        p_bus.rdata = '0;
        pattern_a5  = {(LINE_W/8){8'hA5}};
        rline       = {(LINE_W/32){32'h1234_5678}};

        do_reset();
        check("rst_read",    LINE_W'(p_bus.read), '0);
        check("rst_write",   LINE_W'(p_bus.write), '0);
        check("rst_addr",    LINE_W'(p_bus.address), '0);
        check("rst_tmo",     LINE_W'(timeout_err), '0);

        // Single I read at 0x100, response three cycles after the request appears
        i_bus.read = 1'b1; i_bus.address = 32'h100;
        #1;
        check("t1_idle_read", LINE_W'(p_bus.read), '0);
        tick();
        check("t1_read",  LINE_W'(p_bus.read), LINE_W'(1));
        check("t1_write", LINE_W'(p_bus.write), '0);
        check("t1_addr",  LINE_W'(p_bus.address), LINE_W'(32'h100));
        tick(); tick();
        check("t1_read_held", LINE_W'(p_bus.read), LINE_W'(1));
        check("t1_no_resp", LINE_W'(i_bus.resp), '0);
        respond("t1", 1'b1, rline);
        tick();
        i_bus.read = 1'b0;
        check("t1_release_read", LINE_W'(p_bus.read), '0);
        #1;
        check("t1_release_resp", LINE_W'(i_bus.resp), '0);
        p_bus.resp = 1'b0;
        tick();

        // Simultaneous I and D after reset: I first, D granted two cycles after I's resp
        do_reset();
        i_bus.read = 1'b1; i_bus.address = 32'h300;
        d_bus.read = 1'b1; d_bus.address = 32'h400;
        tick();
        check("t2_first_addr", LINE_W'(p_bus.address), LINE_W'(32'h300));
        respond("t2_i", 1'b1, rline);
        tick();
        i_bus.read = 1'b0; p_bus.resp = 1'b0;
        check("t2_release", LINE_W'(p_bus.read), '0);
        tick();
        check("t2_idle", LINE_W'(p_bus.read), '0);
        tick();
        check("t2_d_read", LINE_W'(p_bus.read), LINE_W'(1));
        check("t2_d_addr", LINE_W'(p_bus.address), LINE_W'(32'h400));
        respond("t2_d", 1'b0, ~rline);
        tick();
        d_bus.read = 1'b0; p_bus.resp = 1'b0;
        tick();

        // D write latched at grant; later address/data changes and I pending do not disturb it
        d_bus.write = 1'b1; d_bus.address = 32'h200; d_bus.wdata = pattern_a5;
        tick();
        check("t3_write", LINE_W'(p_bus.write), LINE_W'(1));
        check("t3_read",  LINE_W'(p_bus.read), '0);
        i_bus.read = 1'b1; i_bus.address = 32'h500;
        d_bus.address = 32'h999; d_bus.wdata = '0;
        tick();
        check("t3_addr_latched",  LINE_W'(p_bus.address), LINE_W'(32'h200));
        check("t3_wdata_latched", p_bus.wdata, pattern_a5);
        respond("t3_d", 1'b0, rline);
        tick();
        d_bus.write = 1'b0; p_bus.resp = 1'b0;
        tick(); tick();
        check("t3_i_granted", LINE_W'(p_bus.address), LINE_W'(32'h500));
        check("t3_i_read",    LINE_W'(p_bus.read), LINE_W'(1));

        // Back-to-back I requests with D waiting: I, D, I
        d_bus.read = 1'b1; d_bus.address = 32'h600;
        respond("t4_i0", 1'b1, rline);
        tick(); p_bus.resp = 1'b0;
        tick(); tick();
        check("t4_d_turn", LINE_W'(p_bus.address), LINE_W'(32'h600));
        i_bus.write = 1'b1; i_bus.address = 32'h700;
        respond("t4_d", 1'b0, rline);
        tick(); p_bus.resp = 1'b0; d_bus.read = 1'b0;
        tick(); tick();
        check("t4_i_turn",  LINE_W'(p_bus.address), LINE_W'(32'h700));
        check("t4_wr_wins", LINE_W'(p_bus.write), LINE_W'(1));
        check("t4_rd_off",  LINE_W'(p_bus.read), '0);
        respond("t4_i1", 1'b1, rline);
        tick(); p_bus.resp = 1'b0; i_bus.read = 1'b0; i_bus.write = 1'b0;
        tick();

        // Watchdog: flag rises after 2**TMO_W-1 SERVE cycles, stays set, later resp still completes
        i_bus.read = 1'b1; i_bus.address = 32'h800;
        tick();
        repeat ((1 << TMO_W) - 2) tick();
        check("t5_tmo_early", LINE_W'(timeout_err), '0);
        tick();
        check("t5_tmo_set", LINE_W'(timeout_err), LINE_W'(1));
        tick(); tick();
        check("t5_tmo_sticky", LINE_W'(timeout_err), LINE_W'(1));
        check("t5_still_read", LINE_W'(p_bus.read), LINE_W'(1));
        respond("t5", 1'b1, rline);
        tick(); p_bus.resp = 1'b0;
        check("t5_tmo_after", LINE_W'(timeout_err), LINE_W'(1));
        check("t5_read_clr",  LINE_W'(p_bus.read), '0);
        tick();

        // Reset during SERVE aborts the transaction without a response
        tick();
        check("t6_serving", LINE_W'(p_bus.read), LINE_W'(1));
        rst = 1'b0; p_bus.resp = 1'b1;
        #1;
        check("t6_no_resp_rst", LINE_W'(i_bus.resp), '0);
        tick();
        check("t6_read",  LINE_W'(p_bus.read), '0);
        check("t6_write", LINE_W'(p_bus.write), '0);
        check("t6_tmo",   LINE_W'(timeout_err), '0);
        check("t6_resp",  LINE_W'(i_bus.resp), '0);
        rst = 1'b1; p_bus.resp = 1'b0;
        tick();
        check("t6_regrant", LINE_W'(p_bus.read), LINE_W'(1));
        i_bus.read = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
